// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles little-endian words from a byte stream,
// writes them to imem and holds the core until a complete image is in place.
// Optional trailing XOR checksum byte is enabled by defining CHECKSUM_EN.
module imem_loader #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [63:0] BASE_ADDR   = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [63:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] words_written
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
`ifdef CHECKSUM_EN
        CSUM   = 3'd4,
`endif
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH_WORDS);

`ifdef CHECKSUM_EN
    function automatic logic [7:0] xor_byte(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    state_t      state_r, state_s;
    logic [15:0] len_r, len_s;
    logic [1:0]  byte_idx_r, byte_idx_s;
    logic [23:0] word_buf_r, word_buf_s;
    logic        rx_ready_r, rx_ready_s;
    logic        imem_we_r, imem_we_s;
    logic [63:0] imem_addr_r, imem_addr_s;
    logic [31:0] imem_wdata_r, imem_wdata_s;
    logic        cpu_hold_r, cpu_hold_s;
    logic        load_done_r, load_done_s;
    logic        load_err_r, load_err_s;
    logic [15:0] words_written_r, words_written_s;
    logic        accept_s;
    logic [15:0] len_full_s;
`ifdef CHECKSUM_EN
    logic [7:0]  csum_r, csum_s;
`endif

    assign accept_s   = rx_valid && rx_ready_r;
    assign len_full_s = {rx_data, len_r[7:0]};

    // Next-state and next-output computation for every register.
    always_comb begin
        state_s         = state_r;
        len_s           = len_r;
        byte_idx_s      = byte_idx_r;
        word_buf_s      = word_buf_r;
        imem_we_s       = 1'b0;
        imem_addr_s     = imem_addr_r;
        imem_wdata_s    = imem_wdata_r;
        words_written_s = words_written_r;
`ifdef CHECKSUM_EN
        csum_s          = csum_r;
`endif
        case (state_r)
            IDLE: begin
                if (load_start) begin
                    state_s         = LEN_LO;
                    words_written_s = 16'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            LEN_LO: begin
                if (accept_s) begin
                    len_s[7:0] = rx_data;
                    state_s    = LEN_HI;
                end else begin
                    state_s = LEN_LO;
                end
            end
            LEN_HI: begin
                if (accept_s) begin
                    len_s           = len_full_s;
                    byte_idx_s      = 2'd0;
                    words_written_s = 16'd0;
`ifdef CHECKSUM_EN
                    csum_s          = 8'h00;
`endif
                    if (len_full_s == 16'd0) begin
`ifdef CHECKSUM_EN
                        state_s = CSUM;
`else
                        state_s = DONE;
`endif
                    end else if (len_full_s > DEPTH_W) begin
                        state_s = ERR;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = LEN_HI;
                end
            end
            DATA: begin
                if (accept_s) begin
`ifdef CHECKSUM_EN
                    csum_s = xor_byte(csum_r, rx_data);
`endif
                    byte_idx_s = byte_idx_r + 2'd1;
                    case (byte_idx_r)
                        2'd0:    word_buf_s[7:0]   = rx_data;
                        2'd1:    word_buf_s[15:8]  = rx_data;
                        2'd2:    word_buf_s[23:16] = rx_data;
                        default: begin
                            imem_we_s       = 1'b1;
                            imem_wdata_s    = {rx_data, word_buf_r};
                            imem_addr_s     = BASE_ADDR + {46'd0, words_written_r, 2'b00};
                            words_written_s = words_written_r + 16'd1;
                        end
                    endcase
                    // Length is at least 1 here, so the count can only meet len on a word boundary.
                    if ((byte_idx_r == 2'd3) && ((words_written_r + 16'd1) == len_r)) begin
`ifdef CHECKSUM_EN
                        state_s = CSUM;
`else
                        state_s = DONE;
`endif
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
`ifdef CHECKSUM_EN
            CSUM: begin
                if (accept_s) begin
                    state_s = (rx_data == csum_r) ? DONE : ERR;
                end else begin
                    state_s = CSUM;
                end
            end
`endif
            DONE, ERR: begin
                if (load_start) begin
                    state_s         = LEN_LO;
                    words_written_s = 16'd0;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Status flags follow the state a cycle late so done is never seen alongside the final write.
        load_done_s = (state_s == DONE) && (state_r == DONE);
        load_err_s  = (state_s == ERR) && (state_r == ERR);
        cpu_hold_s  = !load_done_s;
`ifdef CHECKSUM_EN
        rx_ready_s  = (state_s == LEN_LO) || (state_s == LEN_HI) ||
                      (state_s == DATA) || (state_s == CSUM);
`else
        rx_ready_s  = (state_s == LEN_LO) || (state_s == LEN_HI) || (state_s == DATA);
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            len_r           <= 16'd0;
            byte_idx_r      <= 2'd0;
            word_buf_r      <= 24'd0;
            rx_ready_r      <= 1'b0;
            imem_we_r       <= 1'b0;
            imem_addr_r     <= BASE_ADDR;
            imem_wdata_r    <= 32'd0;
            cpu_hold_r      <= 1'b1;
            load_done_r     <= 1'b0;
            load_err_r      <= 1'b0;
            words_written_r <= 16'd0;
`ifdef CHECKSUM_EN
            csum_r          <= 8'h00;
`endif
        end else begin
            state_r         <= state_s;
            len_r           <= len_s;
            byte_idx_r      <= byte_idx_s;
            word_buf_r      <= word_buf_s;
            rx_ready_r      <= rx_ready_s;
            imem_we_r       <= imem_we_s;
            imem_addr_r     <= imem_addr_s;
            imem_wdata_r    <= imem_wdata_s;
            cpu_hold_r      <= cpu_hold_s;
            load_done_r     <= load_done_s;
            load_err_r      <= load_err_s;
            words_written_r <= words_written_s;
`ifdef CHECKSUM_EN
            csum_r          <= csum_s;
`endif
        end
    end

    assign rx_ready      = rx_ready_r;
    assign imem_we       = imem_we_r;
    assign imem_addr     = imem_addr_r;
    assign imem_wdata    = imem_wdata_r;
    assign cpu_hold      = cpu_hold_r;
    assign load_done     = load_done_r;
    assign load_err      = load_err_r;
    assign words_written = words_written_r;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory interface. The core only ever reads instruction memory; this block fills it from a byte stream (UART/JTAG bridge) before execution. It assembles little-endian 32-bit words, drives a write port into instruction memory, and holds the core in reset until a complete program image has been written.

Parameters:
DEPTH_WORDS, 64, instruction memory capacity in 32-bit words; an image longer than this is rejected.
BASE_ADDR, 64'd0, byte address of the first word written; matches the PC reset value.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
load_start  input  1  single-cycle pulse; begins a new image load
rx_valid  input  1  byte-stream valid
rx_data  input  8  byte-stream data
rx_ready  output  1  block can accept a byte this cycle
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  64  byte address of word being written (BASE_ADDR + 4*index)
imem_wdata  output  32  assembled instruction word
cpu_hold  output  1  drives the core's PC/pipeline reset while high
load_done  output  1  level; image fully written, core released
load_err  output  1  level; image rejected
words_written  output  16  count of words written in the current load

Behaviour:
- Reset values: rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, load_done=0, load_err=0, words_written=0, state=IDLE. The core is held from power-up until the first successful load.
- All outputs are registered. A byte transfers only when rx_valid && rx_ready in the same cycle. rx_data is ignored otherwise.
- FSM states and transitions:
  - IDLE: rx_ready=0. load_start moves to LEN_LO.
  - LEN_LO: rx_ready=1. The accepted byte becomes len[7:0]; go to LEN_HI.
  - LEN_HI: rx_ready=1. The accepted byte becomes len[15:8]. Then:
    - len==0: go to DONE.
    - len>DEPTH_WORDS: go to ERR.
    - otherwise: go to DATA. byte_idx and word_idx are cleared.
  - DATA: rx_ready=1. Byte k of each word goes to bits [8k+7:8k], so the first byte lands in [7:0].
    - When the 4th byte is accepted in cycle N, cycle N+1 has imem_we=1, imem_addr=BASE_ADDR+4*word_idx, imem_wdata=assembled word, and words_written incremented.
    - When word_idx reaches len, the state is DONE at N+1.
  - DONE: cpu_hold=0, load_done=1, rx_ready=0. Both are visible from the cycle after the last imem_we.
  - ERR: cpu_hold=1, load_err=1, rx_ready=0.
- load_start handling:
  - In DONE or ERR: restarts the load (goes to LEN_LO). It clears load_done, load_err and words_written, and sets cpu_hold=1 in the next cycle.
  - In LEN_LO, LEN_HI, DATA or CSUM: ignored.
- imem_we is never high for more than one consecutive cycle, even with rx_valid tied high. The minimum spacing between writes is 4 cycles.
- Stalls: rx_valid low mid-word keeps the partial word and byte_idx indefinitely. There is no timeout.
- Reset mid-load: immediate return to reset values. Words already written stay in memory, and the core remains held.
- Wrap-around is impossible because a length greater than DEPTH_WORDS is rejected before any write.

Optional Feature:
Macro CHECKSUM_EN.
- Defined: after the last word, the FSM enters CSUM with rx_ready=1 instead of going to DONE. The accepted byte is compared with the XOR of every image byte (length bytes excluded). The FSM goes to DONE on a match and to ERR on a mismatch, one cycle after acceptance. For len==0 the expected checksum is 8'h00, and CSUM still follows LEN_HI.
- Not defined: the CSUM state and the XOR accumulator are absent, and the behaviour is exactly as above.

Test Plan:
- Reset then idle 10 cycles -> cpu_hold=1, rx_ready=0, imem_we=0, load_done=0.
- load_start; bytes 02 00, 13 05 A0 00, 93 05 30 00 -> imem_we at 0x0 with 0x00A00513, then at 0x4 with 0x00300593. Afterwards words_written=2, load_done=1, cpu_hold=0.
- Length bytes 41 00 with DEPTH_WORDS=64 -> load_err=1, cpu_hold=1, no imem_we pulse.
- rx_valid toggled randomly during a 3-word load -> same 3 writes, correct addresses 0x0/0x4/0x8, one imem_we per word.
- Assert reset after 2 of 4 data bytes, then reload a 1-word image -> first imem_we is at address 0x0 with the new word, and no stale bytes are merged in.
- With CHECKSUM_EN: image 01 00 13 05 A0 00 followed by checksum B6 -> load_done=1. The same image with checksum B7 -> load_err=1.
